arb_mux_reg: RTL
================

# arb_mux_reg

Parametrised successor to the plain generic multiplexer: instead of an external selector, it arbitrates among NUM_INPUTS valid/ready channels and registers the winning word into a one-entry output stage. Selection is round-robin or fixed-priority, set by a mode parameter. It sits wherever several producers share one consumer, such as warp issue slots feeding a shared functional unit or several lanes feeding a writeback port. Throughput is one word per cycle; latency is one cycle.

## Interface
- INPUT_WIDTH, 32, bits per data word
- NUM_INPUTS, 32, number of requesting channels, ≥1
- SEL_WIDTH, max(1, $clog2(NUM_INPUTS)), width of index fields
- ARB_MODE, ARB_RR, ARB_RR = round-robin, ARB_FIXED = lowest index wins
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  [INPUT_WIDTH-1:0] x [NUM_INPUTS-1:0] (unpacked array)  per-channel data
- in_valid  in  NUM_INPUTS  per-channel request
- in_ready  out  NUM_INPUTS  per-channel accept, at most one bit set
- out_data  out  INPUT_WIDTH  registered winning word
- out_idx  out  SEL_WIDTH  channel index that produced out_data
- out_valid  out  1  output stage holds a word
- out_ready  in  1  consumer accepts out_data

## Operation
- load_en = !out_valid || out_ready.
- Pick: among set in_valid bits, take the first index at or above ptr, wrapping modulo NUM_INPUTS. In ARB_FIXED mode ptr is treated as 0.
- in_ready = one-hot of the pick when load_en and at least one in_valid is set; otherwise all zero. in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on channel g when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= in_data[g]
  - out_idx <= g
  - out_valid <= 1
- If load_en and no request is valid, out_valid <= 0 (drain). out_data and out_idx then hold their old values.
- If out_valid && !out_ready, the output stage holds, all in_ready = 0 and ptr holds.
- Pointer (ARB_RR only):
  - on a transfer on g, ptr <= (g == NUM_INPUTS-1) ? 0 : g+1
  - this wraps correctly for non-power-of-two NUM_INPUTS
  - otherwise ptr holds
- The output stage never drops or duplicates a word. Each accepted input appears exactly once on out_* with out_valid && out_ready.
- NUM_INPUTS=1: ptr is constant 0, out_idx is always 0, and the block behaves as a one-stage pipeline register.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, ptr=0. in_ready is all zero during rst.
- rst has priority over every transfer in the same cycle. Any word held in the output stage is discarded. A producer that saw in_ready high in a cycle where rst was high has not transferred.
- Latency: an input accepted at edge N has out_valid=1 with its data from edge N onward, visible in cycle N+1.
- Sustained throughput is one word per cycle when out_ready is held high.
- Simultaneous drain and fill (out_valid && out_ready && a grant): the output stage is replaced in the same edge with no bubble.
- Fairness (RR): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_INPUTS-1,0…. Any continuously valid channel is granted within NUM_INPUTS transfers.

## Structure
- Shared package arb_pkg holds:
  - localparams ARB_RR=0 and ARB_FIXED=1
  - a function for the index width, max(1, $clog2(n)), used to derive SEL_WIDTH
- Sub-module rr_pick: combinational rotating priority encoder.
  - Parameters NUM_INPUTS and SEL_WIDTH.
  - Inputs req[NUM_INPUTS] and ptr[SEL_WIDTH].
  - Outputs gnt_onehot, gnt_idx and any_req.
  - Reused for ARB_FIXED by tying ptr to 0.
- Top level holds ptr, the output stage registers and the load_en/handshake logic. The data select is in_data[gnt_idx].

## Test plan
- Reset mid-stream: out_valid=1 holding 0xAAAA, assert rst for one cycle with in_valid=all ones. Required next cycle: out_valid=0, out_data=0, out_idx=0, ptr=0. After rst drops, the first grant goes to channel 0.
- RR fairness (NUM_INPUTS=5): all channels valid, data = 0x10+i, out_ready=1. Required out_idx sequence 0,1,2,3,4,0,1 on consecutive cycles with matching data, showing the wrap at the non-power-of-two boundary.
- Backpressure: channel 2 valid with 0x55, out_ready=0 for 3 cycles. Required:
  - exactly one transfer, then in_ready all zero
  - out_data=0x55 and out_idx=2 stable through the stall
  - after out_ready=1, exactly one output beat of 0x55, with no duplicate
- Simultaneous drain and fill: out_valid=1 (0x01, idx 0), out_ready=1, channel 3 valid with 0x03. Required next cycle: out_data=0x03, out_idx=3, out_valid=1, with no bubble.
- Fixed mode (ARB_FIXED, NUM_INPUTS=4): channels 1 and 3 continuously valid. Required: channel 1 is granted every cycle and channel 3 is never granted until channel 1 deasserts.
- Skip idle channels (RR, ptr=1 after a grant on 0): only channels 0 and 3 valid. Required grant order 3, then 0, then 3.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode constants and index-width helper
package arb_pkg;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first request at or above ptr wins
module rr_pick #(
  parameter int NUM_INPUTS = 32,
  parameter int SEL_WIDTH  = 5
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  output logic [NUM_INPUTS-1:0] gnt_onehot,
  output logic [SEL_WIDTH-1:0]  gnt_idx,
  output logic                  any_req
);
  assign any_req    = |req;
  assign gnt_onehot = any_req ? (NUM_INPUTS'(1) << gnt_idx) : '0;
  // scan offsets from farthest to nearest so the nearest request at or above ptr wins
  always_comb begin
    int i;
    gnt_idx = '0;
    i = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      i = int'(ptr) + k;
      i = (i >= NUM_INPUTS) ? i - NUM_INPUTS : i;
      if (req[i]) gnt_idx = SEL_WIDTH'(i);
    end
  end
endmodule

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: arbitrated valid/ready mux with a one-entry registered output stage
module arb_mux_reg
  import arb_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int NUM_INPUTS  = 32,
  parameter int SEL_WIDTH   = idx_width(NUM_INPUTS),
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0]  in_valid,
  output logic [NUM_INPUTS-1:0]  in_ready,
  output logic [INPUT_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]   out_idx,
  output logic                   out_valid,
  input  logic                   out_ready
);
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  pick_ptr;
  logic [NUM_INPUTS-1:0] gnt_onehot;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic                  any_req;
  logic                  load_en;
  assign load_en  = !out_valid || out_ready;
  assign pick_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
  assign in_ready = (load_en && !rst) ? gnt_onehot : '0;
  rr_pick #(.NUM_INPUTS(NUM_INPUTS), .SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req       (in_valid),
    .ptr       (pick_ptr),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any_req   (any_req)
  );
  // output stage loads the winner or drains when free; pointer advances past each winner
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data <= in_data[gnt_idx];
        out_idx  <= gnt_idx;
        if (ARB_MODE == ARB_RR)
          ptr <= (gnt_idx == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule
